procb_state_xfer: RTL and testbench
===================================

# procb_state_xfer

Save/restore controller for per-thread process_bytes state in the sha512crypt engine. It sits between the process_bytes unit and the per-thread saved-state RAM, which has a registered read port with one-cycle latency. On a block boundary it writes the unfinished record state (bytes_total plus pending data and padding) for a thread. When that thread resumes, it reads the state back through a valid/ack handshake. A per-thread occupancy bitmap lets threads with nothing saved restore immediately as all-zero without touching the RAM.

## Interface
- N_THREADS, `N_THREADS: number of threads.
- N_THREADS_MSB, `MSB(N_THREADS-1): thread-number MSB.
- WIDTH, `PROCB_SAVE_WIDTH: saved-state word width.

- CLK  in  1  clock; all logic on posedge.
- RESET_N  in  1  asynchronous active-low reset.
- save_req  in  1  request to save state of save_thread_num.
- save_thread_num  in  N_THREADS_MSB+1  thread to save.
- save_data  in  WIDTH  state to save.
- save_ready  out  1  save accepted when save_req & save_ready.
- restore_req  in  1  request to restore restore_thread_num.
- restore_thread_num  in  N_THREADS_MSB+1  thread to restore.
- restore_ready  out  1  restore accepted when restore_req & restore_ready.
- restore_valid  out  1  restore_data/restore_empty valid.
- restore_data  out  WIDTH  restored state (0 when empty).
- restore_empty  out  1  thread had no saved state.
- restore_ack  in  1  consumer takes the result; legal only with restore_valid.
- mem_wr_en  out  1  RAM write strobe.
- mem_wr_thread_num  out  N_THREADS_MSB+1  RAM write address.
- mem_din  out  WIDTH  RAM write data.
- mem_rd_en  out  1  RAM read strobe.
- mem_rd_thread_num  out  N_THREADS_MSB+1  RAM read address.
- mem_dout  in  WIDTH  RAM read data, valid the cycle after mem_rd_en.

## Operation
- Bitmap `saved[N_THREADS]`:
  - Bit set on an accepted save.
  - Bit cleared on an accepted restore (see Configuration).
  - If both hit the same thread in one cycle, the save wins.
- Save path is combinational pass-through:
  - mem_wr_en = save_req & save_ready.
  - mem_wr_thread_num = save_thread_num; mem_din = save_data.
- Restore FSM states:
  - IDLE: restore_ready=1 unless blocked. On accept, latch the thread number.
    - Bit set: go to READ.
    - Bit clear: go to VALID with restore_data=0, restore_empty=1.
  - READ: mem_rd_en=1, mem_rd_thread_num=latched thread; go to LOAD.
  - LOAD: capture mem_dout into restore_data, restore_empty=0; go to VALID.
  - VALID: restore_valid=1, outputs held stable. On restore_ack, go to IDLE, restore_valid=0 next cycle.
- Hazards:
  - IDLE, save_req and restore_req on the same thread: restore_ready=0 that cycle and the save proceeds.
  - READ, save_req on the latched thread: save_ready=0.
  - save_ready=1 in every other case.
- restore_ready=0 in READ, LOAD and VALID; there is no back-to-back accept in the VALID→IDLE cycle.
- Reset (asynchronous, any state, including mid-read):
  - FSM to IDLE; bitmap all 0.
  - restore_valid=0, restore_empty=0, restore_data=0, mem_rd_en=0.
  - mem_wr_en=0 while RESET_N is low; save_ready=0, restore_ready=0 during reset.
  - A read in flight is abandoned and mem_dout is ignored.

## Timing
- Restore, saved thread: accept at cycle 0, mem_rd_en at 1, capture at 2, restore_valid from 3.
- Restore, empty thread: accept at cycle 0, restore_valid from 1.
- Save: written to RAM at the accepting edge. A restore of that thread accepted the next cycle returns the new data.
- Throughput: one restore per 4 cycles (saved thread) or 2 cycles (empty thread) with immediate ack. One save per cycle.

## Configuration
- PROCB_RESTORE_CLEAR_EN defined: an accepted restore clears the thread's bitmap bit, so the state is consumed once. A second restore returns empty.
- Not defined: bits are cleared only by reset. Every restore after the first save reads the RAM; saves overwrite.

## Test plan
- Reset, then restore thread 3 -> restore_valid at cycle 1, restore_empty=1, restore_data=0, mem_rd_en never asserted.
- Save thread 5 data 0xA5A5, then restore 5 -> mem_wr_en at the accept edge with address 5; mem_rd_en at cycle 1; restore_valid at cycle 3, data 0xA5A5, empty=0.
- Same-cycle save and restore of thread 2 -> restore_ready=0, save written; restore accepted the next cycle returns the saved data.
- Save to thread 7 while the FSM is in READ for 7 -> save_ready=0 for exactly that cycle. Save to thread 6 in the same cycle -> accepted.
- Hold restore_ack low 10 cycles -> restore_valid and restore_data stable; ack -> restore_valid=0 next cycle, restore_ready=1.
- RESET_N low during LOAD -> restore_valid stays 0, bitmap cleared. With PROCB_RESTORE_CLEAR_EN, a double restore of a saved thread returns empty the second time.

Source files
------------

// File: rtl/procb_state_xfer.sv
// Save/restore controller for per-thread process_bytes record state, fronting a 1-cycle-latency RAM.
// Optional feature macro PROCB_RESTORE_CLEAR_EN: an accepted restore consumes (clears) the thread's saved bit.
module procb_state_xfer #(
  parameter int N_THREADS     = 8,
  parameter int N_THREADS_MSB = $clog2(N_THREADS) - 1,
  parameter int WIDTH         = 32
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic                   save_req,
  input  logic [N_THREADS_MSB:0] save_thread_num,
  input  logic [WIDTH-1:0]       save_data,
  output logic                   save_ready,
  input  logic                   restore_req,
  input  logic [N_THREADS_MSB:0] restore_thread_num,
  output logic                   restore_ready,
  output logic                   restore_valid,
  output logic [WIDTH-1:0]       restore_data,
  output logic                   restore_empty,
  input  logic                   restore_ack,
  output logic                   mem_wr_en,
  output logic [N_THREADS_MSB:0] mem_wr_thread_num,
  output logic [WIDTH-1:0]       mem_din,
  output logic                   mem_rd_en,
  output logic [N_THREADS_MSB:0] mem_rd_thread_num,
  input  logic [WIDTH-1:0]       mem_dout
);

  typedef enum logic [1:0] {IDLE, READ, LOAD, VALID} state_t;

  state_t                 state_q, state_d;
  logic [N_THREADS_MSB:0] thr_q, thr_d;
  logic [WIDTH-1:0]       data_q, data_d;
  logic                   empty_q, empty_d;
  logic [N_THREADS-1:0]   saved_q, saved_d;
  logic                   save_acc;
  logic                   restore_acc;

  // A save to the thread being read this cycle would collide on the same RAM address.
  assign save_ready = RESET_N && !((state_q == READ) && (save_thread_num == thr_q));
  assign save_acc   = save_req && save_ready;

  assign restore_ready = RESET_N && (state_q == IDLE) &&
                         !(save_req && (save_thread_num == restore_thread_num));
  assign restore_acc   = restore_req && restore_ready;

  assign mem_wr_en         = save_acc;
  assign mem_wr_thread_num = save_thread_num;
  assign mem_din           = save_data;

  assign mem_rd_en         = (state_q == READ);
  assign mem_rd_thread_num = thr_q;

  assign restore_valid = (state_q == VALID);
  assign restore_data  = data_q;
  assign restore_empty = empty_q;

  // Save is applied after the clear so it wins when both target one thread.
  always_comb begin
    saved_d = saved_q;
`ifdef PROCB_RESTORE_CLEAR_EN
    if (restore_acc) saved_d[restore_thread_num] = 1'b0;
`else
`endif
    if (save_acc) saved_d[save_thread_num] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    thr_d   = thr_q;
    data_d  = data_q;
    empty_d = empty_q;
    case (state_q)
      IDLE: begin
        if (restore_acc) begin
          thr_d = restore_thread_num;
          if (saved_q[restore_thread_num]) begin
            state_d = READ;
          end else begin
            state_d = VALID;
            data_d  = '0;
            empty_d = 1'b1;
          end
        end
      end
      READ: state_d = LOAD;
      LOAD: begin
        data_d  = mem_dout;
        empty_d = 1'b0;
        state_d = VALID;
      end
      VALID: begin
        if (restore_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      thr_q   <= '0;
      data_q  <= '0;
      empty_q <= 1'b0;
      saved_q <= '0;
    end else begin
      state_q <= state_d;
      thr_q   <= thr_d;
      data_q  <= data_d;
      empty_q <= empty_d;
      saved_q <= saved_d;
    end
  end

endmodule

// File: tb/tb_procb_state_xfer.sv
// Scoreboard bench for procb_state_xfer: behavioural RAM, shadow bitmap/memory model, queue of expected restores.
module tb_procb_state_xfer;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        saveReq = 1'b0;
  logic [2:0]  saveThr = '0;
  logic [31:0] saveData = '0;
  logic        restoreReq = 1'b0;
  logic [2:0]  restoreThr = '0;
  logic        restoreAck = 1'b0;
  logic        saveReady, restoreReady, restoreValid, restoreEmpty;
  logic [31:0] restoreData, memDin;
  logic        memWrEn, memRdEn;
  logic [2:0]  memWrThr, memRdThr;
  logic [31:0] memDout;
  logic [31:0] ram [8];

  int assertCount = 0;
  int failCount = 0;

  // Shadow of what the controller should have saved, independent of the DUT.
  logic [31:0] expMem [8];
  logic [7:0]  expSaved = '0;

  typedef struct packed {
    logic        empty;
    logic [31:0] data;
  } exp_t;
  exp_t sbQueue[$];

  procb_state_xfer #(.N_THREADS(8), .N_THREADS_MSB(2), .WIDTH(32)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .save_req(saveReq), .save_thread_num(saveThr), .save_data(saveData), .save_ready(saveReady),
    .restore_req(restoreReq), .restore_thread_num(restoreThr), .restore_ready(restoreReady),
    .restore_valid(restoreValid), .restore_data(restoreData), .restore_empty(restoreEmpty),
    .restore_ack(restoreAck),
    .mem_wr_en(memWrEn), .mem_wr_thread_num(memWrThr), .mem_din(memDin),
    .mem_rd_en(memRdEn), .mem_rd_thread_num(memRdThr), .mem_dout(memDout)
  );

  always #5 CLK = ~CLK;

  // Saved-state RAM with a registered read port.
  always @(posedge CLK) begin
    if (memWrEn) ram[memWrThr] <= memDin;
    if (memRdEn) memDout <= ram[memRdThr];
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic midCycle();
    @(negedge CLK);
  endtask

  // Single save issued from IDLE; always expected to be accepted.
  task automatic saveCycle(input logic [2:0] thr, input logic [31:0] data);
    saveReq = 1'b1; saveThr = thr; saveData = data;
    midCycle();
    checkOutput("save_ready", saveReady, 1);
    checkOutput("mem_wr_en", memWrEn, 1);
    checkOutput("mem_wr_thread_num", memWrThr, thr);
    checkOutput("mem_din", memDin, data);
    expSaved[thr] = 1'b1;
    expMem[thr] = data;
    nextCycle();
    saveReq = 1'b0;
  endtask

  // Full restore transaction; optionally drives a save during the two cycles after accept.
  task automatic doRestore(input logic [2:0] thr, input int ackDelay, input bit inject,
                           input logic [2:0] injThr, input logic [31:0] injData);
    exp_t e;
    bit   wasSaved;
    bit   found;
    bit   expRdy;
    int   rdCount;
    int   lat;
    restoreReq = 1'b1; restoreThr = thr;
    midCycle();
    checkOutput("restore_ready_accept", restoreReady, 1);
    wasSaved = expSaved[thr];
    e.empty = !wasSaved;
    e.data  = wasSaved ? expMem[thr] : 32'h0;
    sbQueue.push_back(e);
`ifdef PROCB_RESTORE_CLEAR_EN
    expSaved[thr] = 1'b0;
`endif
    nextCycle();
    restoreReq = 1'b0;
    rdCount = 0; found = 1'b0; lat = 0;
    for (int cyc = 1; cyc <= 20 && !found; cyc++) begin
      if (inject && (cyc == 1 || cyc == 2)) begin
        saveReq = 1'b1; saveThr = injThr; saveData = injData;
      end
      midCycle();
      if (memRdEn) begin
        rdCount++;
        checkOutput("mem_rd_thread_num", memRdThr, thr);
        checkOutput("mem_rd_cycle", cyc, 1);
      end
      if (inject && (cyc == 1 || cyc == 2)) begin
        expRdy = !(cyc == 1 && wasSaved && injThr == thr);
        checkOutput(cyc == 1 ? "save_ready_in_read" : "save_ready_after_read", saveReady, expRdy);
        checkOutput("mem_wr_en_inject", memWrEn, expRdy);
        if (expRdy) begin
          expSaved[injThr] = 1'b1;
          expMem[injThr] = injData;
        end
      end
      if (restoreValid) begin
        found = 1'b1;
        lat = cyc;
      end else begin
        checkOutput("restore_ready_busy", restoreReady, 0);
        nextCycle();
        if (inject && cyc == 2) saveReq = 1'b0;
      end
    end
    saveReq = 1'b0;
    if (!found) begin
      checkOutput("restore_valid_timeout", 0, 1);
      sbQueue.delete();
    end else begin
      checkOutput("restore_latency", lat, wasSaved ? 3 : 1);
      checkOutput("mem_rd_count", rdCount, wasSaved ? 1 : 0);
      e = sbQueue.pop_front();
      checkOutput("restore_data", restoreData, e.data);
      checkOutput("restore_empty", restoreEmpty, e.empty);
      for (int k = 0; k < ackDelay; k++) begin
        nextCycle();
        midCycle();
        checkOutput("valid_held", restoreValid, 1);
        checkOutput("data_held", restoreData, e.data);
        checkOutput("ready_held_low", restoreReady, 0);
      end
      restoreAck = 1'b1;
      nextCycle();
      restoreAck = 1'b0;
      midCycle();
      checkOutput("valid_after_ack", restoreValid, 0);
      checkOutput("ready_after_ack", restoreReady, 1);
    end
    nextCycle();
  endtask

  task automatic applyStimulus();
    logic [2:0]  rThr;
    logic [31:0] rData;
    // Reset state with requests pending.
    saveReq = 1'b1; saveThr = 3'd1; saveData = 32'h1234_5678;
    restoreReq = 1'b1; restoreThr = 3'd3;
    repeat (2) nextCycle();
    midCycle();
    checkOutput("reset_save_ready", saveReady, 0);
    checkOutput("reset_restore_ready", restoreReady, 0);
    checkOutput("reset_mem_wr_en", memWrEn, 0);
    checkOutput("reset_restore_valid", restoreValid, 0);
    checkOutput("reset_restore_data", restoreData, 0);
    checkOutput("reset_restore_empty", restoreEmpty, 0);
    checkOutput("reset_mem_rd_en", memRdEn, 0);
    nextCycle();
    saveReq = 1'b0; restoreReq = 1'b0;
    RESET_N = 1'b1;
    nextCycle();

    // Empty thread, then a saved thread.
    doRestore(3'd3, 0, 1'b0, 3'd0, 32'h0);
    saveCycle(3'd5, 32'h0000_A5A5);
    doRestore(3'd5, 0, 1'b0, 3'd0, 32'h0);

    // Same-cycle save and restore of one thread: save wins, restore retried next cycle.
    saveReq = 1'b1; saveThr = 3'd2; saveData = 32'h2222_0002;
    restoreReq = 1'b1; restoreThr = 3'd2;
    midCycle();
    checkOutput("collide_restore_ready", restoreReady, 0);
    checkOutput("collide_save_ready", saveReady, 1);
    checkOutput("collide_mem_wr_en", memWrEn, 1);
    expSaved[2] = 1'b1; expMem[2] = 32'h2222_0002;
    nextCycle();
    saveReq = 1'b0; restoreReq = 1'b0;
    doRestore(3'd2, 0, 1'b0, 3'd0, 32'h0);

    // Save hazards while the RAM read is outstanding.
    saveCycle(3'd7, 32'h7777_0001);
    doRestore(3'd7, 0, 1'b1, 3'd7, 32'h7777_0002);
    doRestore(3'd7, 0, 1'b0, 3'd0, 32'h0);
    saveCycle(3'd7, 32'h7777_0003);
    doRestore(3'd7, 0, 1'b1, 3'd6, 32'h6666_0006);
    doRestore(3'd6, 0, 1'b0, 3'd0, 32'h0);

    // Long ack stall.
    saveCycle(3'd0, 32'hDEAD_0000);
    doRestore(3'd0, 10, 1'b0, 3'd0, 32'h0);

    // Reset while the captured word is being loaded.
    saveCycle(3'd4, 32'h4444_0004);
    restoreReq = 1'b1; restoreThr = 3'd4;
    midCycle();
    checkOutput("midload_accept", restoreReady, 1);
    nextCycle();
    restoreReq = 1'b0;
    nextCycle();
    RESET_N = 1'b0;
    for (int k = 0; k < 3; k++) begin
      midCycle();
      checkOutput("midload_valid", restoreValid, 0);
      checkOutput("midload_data", restoreData, 0);
      checkOutput("midload_rd_en", memRdEn, 0);
      nextCycle();
    end
    RESET_N = 1'b1;
    expSaved = '0;
    nextCycle();
    midCycle();
    checkOutput("post_reset_valid", restoreValid, 0);
    nextCycle();
    doRestore(3'd4, 0, 1'b0, 3'd0, 32'h0);
    doRestore(3'd5, 0, 1'b0, 3'd0, 32'h0);

    // Double restore of one saved thread.
    saveCycle(3'd1, 32'h1111_0001);
    doRestore(3'd1, 0, 1'b0, 3'd0, 32'h0);
    doRestore(3'd1, 1, 1'b0, 3'd0, 32'h0);

    // Mixed random traffic.
    for (int i = 0; i < 30; i++) begin
      rThr = 3'($urandom_range(0, 7));
      rData = $urandom;
      if ($urandom_range(0, 1) == 1) saveCycle(rThr, rData);
      else doRestore(rThr, $urandom_range(0, 2), 1'b0, 3'd0, 32'h0);
    end
  endtask

  initial begin
    applyStimulus();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
